quantum_interrupt_ctrl: RTL and testbench

Preemption timer and interrupt initiator for the multiprogrammed processor. It counts retired instructions against a quantum loaded by the `writei` instruction. When the quantum expires it raises `intSig` toward the control decoder and holds it until the decoder acknowledges with `stopQnt`, which marks the start of the interrupt sequence. It sits beside the control unit and the PC logic, and supplies the handler address used by the forced jump.

---
 rtl/quantum_interrupt_ctrl_if.sv | 30 +++
 rtl/quantum_interrupt_ctrl.sv | 104 ++++++++++
 tb/tb_quantum_interrupt_ctrl.sv | 271 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/quantum_interrupt_ctrl_if.sv
// Decoder-side signal bundle for the quantum interrupt controller.
// The decoder (master) drives the request inputs, and the controller (slave) answers with the interrupt outputs.
interface quantum_interrupt_ctrl_if #(
  parameter int unsigned QNT_W  = 16,
  parameter int unsigned ADDR_W = 10
);
  logic              instrValid;
  logic              Halt;
  logic              WriteI;
  logic [31:0]       writeData;
  logic              stopQnt;
  logic              intSig;
  logic [ADDR_W-1:0] intAddr;
  logic [QNT_W-1:0]  qntCount;
  logic              armed;
  logic [7:0]        intCount;
  logic [1:0]        dbgState;

  // Handshake: intSig is a level request held high until the edge that
  // samples stopQnt high; stopQnt at any other time carries no meaning.
  modport master (
    output instrValid, Halt, WriteI, writeData, stopQnt,
    input  intSig, intAddr, qntCount, armed, intCount, dbgState
  );

  modport slave (
    input  instrValid, Halt, WriteI, writeData, stopQnt,
    output intSig, intAddr, qntCount, armed, intCount, dbgState
  );
endinterface

// File: rtl/quantum_interrupt_ctrl.sv
// Preemption timer: counts retired instructions against a writei-loaded quantum
// and holds an interrupt request until the decoder acknowledges it.
module quantum_interrupt_ctrl #(
  parameter int unsigned QNT_W        = 16,
  parameter int unsigned ADDR_W       = 10,
  parameter int unsigned DEFAULT_QNT  = 100,
  parameter int unsigned HANDLER_ADDR = 1
) (
  input  logic                     clock,
  input  logic                     reset,
  quantum_interrupt_ctrl_if.slave  bus
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COUNT   = 2'd1,
    ST_PENDING = 2'd2
  } state_t;

  localparam logic [QNT_W-1:0] DEF_Q = QNT_W'(DEFAULT_QNT);
  localparam logic [QNT_W-1:0] ONE_Q = QNT_W'(1);

  state_t           state_q, state_d;
  logic [QNT_W-1:0] qnt_q, qnt_d;
  logic             int_sig_q, int_sig_d;
  logic             armed_q, armed_d;
  logic [7:0]       int_cnt_q, int_cnt_d;
  logic [QNT_W-1:0] load_val;

  // Upper operand bits are architecturally don't-care.
  logic unused_wd;
  assign unused_wd = ^bus.writeData[31:QNT_W];

  // A zero field selects the default quantum, so COUNT never holds zero.
  assign load_val = (bus.writeData[QNT_W-1:0] == '0) ? DEF_Q
                                                     : bus.writeData[QNT_W-1:0];

  always_comb begin
    state_d   = state_q;
    qnt_d     = qnt_q;
    int_sig_d = int_sig_q;
    armed_d   = armed_q;
    int_cnt_d = int_cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.WriteI) begin
          qnt_d   = load_val;
          state_d = ST_COUNT;
          armed_d = 1'b1;
        end
      end
      ST_COUNT: begin
        // Reload beats the final decrement, so a restart never interrupts.
        if (bus.WriteI) begin
          qnt_d = load_val;
        end else if (bus.instrValid && !bus.Halt) begin
          qnt_d = qnt_q - ONE_Q;
          if (qnt_q == ONE_Q) begin
            state_d   = ST_PENDING;
            armed_d   = 1'b0;
            int_sig_d = 1'b1;
          end
        end
      end
      ST_PENDING: begin
        if (bus.stopQnt) begin
          state_d   = ST_IDLE;
          int_sig_d = 1'b0;
          int_cnt_d = int_cnt_q + 8'd1;
        end
      end
      default: begin
        state_d   = ST_IDLE;
        qnt_d     = '0;
        int_sig_d = 1'b0;
        armed_d   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      qnt_q     <= '0;
      int_sig_q <= 1'b0;
      armed_q   <= 1'b0;
      int_cnt_q <= 8'd0;
    end else begin
      state_q   <= state_d;
      qnt_q     <= qnt_d;
      int_sig_q <= int_sig_d;
      armed_q   <= armed_d;
      int_cnt_q <= int_cnt_d;
    end
  end

  assign bus.intSig   = int_sig_q;
  assign bus.armed    = armed_q;
  assign bus.qntCount = qnt_q;
  assign bus.intCount = int_cnt_q;
  assign bus.intAddr  = ADDR_W'(HANDLER_ADDR);
  assign bus.dbgState = state_q;

endmodule

// File: tb/tb_quantum_interrupt_ctrl.sv
// Self-checking bench for quantum_interrupt_ctrl: directed scenarios plus a
// randomized run checked against a rule-level model of the quantum timer.
module tb_quantum_interrupt_ctrl;

  localparam int QNT_W  = 16;
  localparam int ADDR_W = 10;

  logic clock;
  logic reset;
  int   errors;
  int   checks;

  // Reference model: remaining instructions, whether a quantum is running,
  // whether an interrupt is outstanding, and how many acks were taken.
  int m_rem;
  bit m_running;
  bit m_pending;
  int m_acks;

  quantum_interrupt_ctrl_if #(.QNT_W(QNT_W), .ADDR_W(ADDR_W)) bus ();

  quantum_interrupt_ctrl #(
    .QNT_W(QNT_W), .ADDR_W(ADDR_W), .DEFAULT_QNT(100), .HANDLER_ADDR(1)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  // ---------------- clock / reset ----------------
  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic model_clear();
    m_rem     = 0;
    m_running = 0;
    m_pending = 0;
    m_acks    = 0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    model_clear();
  endtask

  // ---------------- model ----------------
  task automatic model_update(input logic wi, input logic [31:0] wd,
                              input logic iv, input logic h, input logic sq);
    if (m_pending) begin
      if (sq) begin
        m_pending = 0;
        m_acks    = m_acks + 1;
      end
    end else if (wi) begin
      m_rem     = (wd % 65536 == 0) ? 100 : int'(wd % 65536);
      m_running = 1;
    end else if (m_running && iv && !h) begin
      m_rem = m_rem - 1;
      if (m_rem == 0) begin
        m_running = 0;
        m_pending = 1;
      end
    end
  endtask

  // ---------------- driver ----------------
  task automatic step(input logic wi, input logic [31:0] wd,
                      input logic iv, input logic h, input logic sq);
    bus.WriteI     = wi;
    bus.writeData  = wd;
    bus.instrValid = iv;
    bus.Halt       = h;
    bus.stopQnt    = sq;
    @(posedge clock);
    model_update(wi, wd, iv, h, sq);
    #1;
    bus.WriteI     = 1'b0;
    bus.writeData  = 32'd0;
    bus.instrValid = 1'b0;
    bus.Halt       = 1'b0;
    bus.stopQnt    = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    do_reset();
    #1;
    checks += 5;
    if (bus.intSig !== 1'b0) begin errors++; $display("FAIL reset_intSig got=%0b exp=0", bus.intSig); end
    if (bus.qntCount !== 16'd0) begin errors++; $display("FAIL reset_qnt got=%0d exp=0", bus.qntCount); end
    if (bus.armed !== 1'b0) begin errors++; $display("FAIL reset_armed got=%0b exp=0", bus.armed); end
    if (bus.intCount !== 8'd0) begin errors++; $display("FAIL reset_intCount got=%0d exp=0", bus.intCount); end
    if (bus.intAddr !== 10'd1) begin errors++; $display("FAIL reset_intAddr got=%0d exp=1", bus.intAddr); end

    // Asynchronous reset mid-cycle while counting with 7 remaining.
    step(1, 32'd7, 0, 0, 0);
    checks += 2;
    if (bus.qntCount !== 16'd7) begin errors++; $display("FAIL async_pre_qnt got=%0d exp=7", bus.qntCount); end
    if (bus.armed !== 1'b1) begin errors++; $display("FAIL async_pre_armed got=%0b exp=1", bus.armed); end
    #3 reset = 1'b1;
    #1;
    checks += 3;
    if (bus.qntCount !== 16'd0) begin errors++; $display("FAIL async_qnt got=%0d exp=0", bus.qntCount); end
    if (bus.armed !== 1'b0) begin errors++; $display("FAIL async_armed got=%0b exp=0", bus.armed); end
    if (bus.intSig !== 1'b0) begin errors++; $display("FAIL async_intSig got=%0b exp=0", bus.intSig); end
    #1 reset = 1'b0;
    model_clear();
  endtask

  task automatic test_basic();
    step(1, 32'd5, 0, 0, 0);
    checks += 2;
    if (bus.qntCount !== 16'd5) begin errors++; $display("FAIL basic_load got=%0d exp=5", bus.qntCount); end
    if (bus.armed !== 1'b1) begin errors++; $display("FAIL basic_armed got=%0b exp=1", bus.armed); end
    for (int k = 1; k <= 5; k++) begin
      step(0, 32'd0, 1, 0, 0);
      checks += 2;
      if (bus.qntCount !== 16'(5 - k)) begin errors++; $display("FAIL basic_qnt k=%0d got=%0d exp=%0d", k, bus.qntCount, 5 - k); end
      if (bus.intSig !== (k == 5)) begin errors++; $display("FAIL basic_intSig k=%0d got=%0b exp=%0b", k, bus.intSig, k == 5); end
    end
    for (int k = 0; k < 3; k++) begin
      step(0, 32'd0, 1, 0, 0);
      checks += 2;
      if (bus.intSig !== 1'b1) begin errors++; $display("FAIL basic_hold_intSig got=%0b exp=1", bus.intSig); end
      if (bus.qntCount !== 16'd0) begin errors++; $display("FAIL basic_hold_qnt got=%0d exp=0", bus.qntCount); end
    end
    step(0, 32'd0, 0, 0, 1);
    checks += 3;
    if (bus.intSig !== 1'b0) begin errors++; $display("FAIL basic_ack_intSig got=%0b exp=0", bus.intSig); end
    if (bus.intCount !== 8'd1) begin errors++; $display("FAIL basic_ack_intCount got=%0d exp=1", bus.intCount); end
    if (bus.armed !== 1'b0) begin errors++; $display("FAIL basic_ack_armed got=%0b exp=0", bus.armed); end
    // Back-to-back: re-arm on the cycle right after the ack edge.
    step(1, 32'd2, 0, 0, 0);
    checks += 2;
    if (bus.armed !== 1'b1) begin errors++; $display("FAIL b2b_armed got=%0b exp=1", bus.armed); end
    if (bus.qntCount !== 16'd2) begin errors++; $display("FAIL b2b_qnt got=%0d exp=2", bus.qntCount); end
  endtask

  task automatic test_zero_default();
    step(1, 32'd0, 0, 0, 0);
    checks++;
    if (bus.qntCount !== 16'd100) begin errors++; $display("FAIL zero_default got=%0d exp=100", bus.qntCount); end
    step(1, 32'h0001_0003, 0, 0, 0);
    checks++;
    if (bus.qntCount !== 16'd3) begin errors++; $display("FAIL upper_bits got=%0d exp=3", bus.qntCount); end
    step(1, 32'h0002_0000, 0, 0, 0);
    checks++;
    if (bus.qntCount !== 16'd100) begin errors++; $display("FAIL upper_only got=%0d exp=100", bus.qntCount); end
  endtask

  task automatic test_halt();
    step(1, 32'd4, 0, 0, 0);
    step(0, 32'd0, 1, 0, 0);
    step(0, 32'd0, 1, 0, 0);
    checks++;
    if (bus.qntCount !== 16'd2) begin errors++; $display("FAIL halt_pre got=%0d exp=2", bus.qntCount); end
    for (int k = 0; k < 10; k++) begin
      step(0, 32'd0, 1, 1, 0);
      checks += 2;
      if (bus.qntCount !== 16'd2) begin errors++; $display("FAIL halt_hold got=%0d exp=2", bus.qntCount); end
      if (bus.intSig !== 1'b0) begin errors++; $display("FAIL halt_intSig got=%0b exp=0", bus.intSig); end
    end
    step(0, 32'd0, 1, 0, 0);
    checks += 2;
    if (bus.qntCount !== 16'd1) begin errors++; $display("FAIL halt_post1 got=%0d exp=1", bus.qntCount); end
    if (bus.intSig !== 1'b0) begin errors++; $display("FAIL halt_post1_int got=%0b exp=0", bus.intSig); end
    step(0, 32'd0, 1, 0, 0);
    checks++;
    if (bus.intSig !== 1'b1) begin errors++; $display("FAIL halt_post2_int got=%0b exp=1", bus.intSig); end
    // Halt must not mask a pending interrupt.
    step(0, 32'd0, 1, 1, 0);
    checks++;
    if (bus.intSig !== 1'b1) begin errors++; $display("FAIL halt_pending got=%0b exp=1", bus.intSig); end
    step(0, 32'd0, 0, 1, 1);
    checks++;
    if (bus.intSig !== 1'b0) begin errors++; $display("FAIL halt_ack got=%0b exp=0", bus.intSig); end
  endtask

  task automatic test_race();
    step(1, 32'd3, 0, 0, 0);
    step(0, 32'd0, 1, 0, 0);
    step(0, 32'd0, 1, 0, 0);
    step(1, 32'd8, 1, 0, 0);
    checks += 2;
    if (bus.qntCount !== 16'd8) begin errors++; $display("FAIL race_qnt got=%0d exp=8", bus.qntCount); end
    if (bus.intSig !== 1'b0) begin errors++; $display("FAIL race_intSig got=%0b exp=0", bus.intSig); end
    repeat (8) step(0, 32'd0, 1, 0, 0);
    checks++;
    if (bus.intSig !== 1'b1) begin errors++; $display("FAIL race_expire got=%0b exp=1", bus.intSig); end
    step(1, 32'd9, 1, 0, 0);
    checks += 3;
    if (bus.qntCount !== 16'd0) begin errors++; $display("FAIL pend_wi_qnt got=%0d exp=0", bus.qntCount); end
    if (bus.intSig !== 1'b1) begin errors++; $display("FAIL pend_wi_int got=%0b exp=1", bus.intSig); end
    if (bus.armed !== 1'b0) begin errors++; $display("FAIL pend_wi_armed got=%0b exp=0", bus.armed); end
    step(0, 32'd0, 0, 0, 1);
  endtask

  task automatic test_wrap_stray();
    do_reset();
    step(0, 32'd0, 1, 0, 1);
    checks += 3;
    if (bus.intCount !== 8'd0) begin errors++; $display("FAIL stray_idle_cnt got=%0d exp=0", bus.intCount); end
    if (bus.armed !== 1'b0) begin errors++; $display("FAIL stray_idle_armed got=%0b exp=0", bus.armed); end
    if (bus.intSig !== 1'b0) begin errors++; $display("FAIL stray_idle_int got=%0b exp=0", bus.intSig); end
    step(1, 32'd2, 0, 0, 0);
    step(0, 32'd0, 0, 0, 1);
    checks += 3;
    if (bus.qntCount !== 16'd2) begin errors++; $display("FAIL stray_count_qnt got=%0d exp=2", bus.qntCount); end
    if (bus.armed !== 1'b1) begin errors++; $display("FAIL stray_count_armed got=%0b exp=1", bus.armed); end
    if (bus.intCount !== 8'd0) begin errors++; $display("FAIL stray_count_cnt got=%0d exp=0", bus.intCount); end
    step(0, 32'd0, 1, 0, 0);
    step(0, 32'd0, 1, 0, 0);
    step(0, 32'd0, 0, 0, 1);
    for (int n = 2; n <= 256; n++) begin
      step(1, 32'd1, 0, 0, 0);
      step(0, 32'd0, 1, 0, 0);
      step(0, 32'd0, 0, 0, 1);
      if (n == 255) begin
        checks++;
        if (bus.intCount !== 8'd255) begin errors++; $display("FAIL wrap_255 got=%0d exp=255", bus.intCount); end
      end
    end
    checks++;
    if (bus.intCount !== 8'd0) begin errors++; $display("FAIL wrap_0 got=%0d exp=0", bus.intCount); end
  endtask

  task automatic test_random();
    logic        wi, iv, h, sq;
    logic [31:0] wd;
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      wi = ($urandom_range(0, 15) == 0);
      wd = {14'd0, 2'($urandom_range(0, 3)), 16'($urandom_range(0, 12))};
      iv = ($urandom_range(0, 3) != 0);
      h  = ($urandom_range(0, 4) == 0);
      sq = ($urandom_range(0, 3) == 0);
      step(wi, wd, iv, h, sq);
      checks += 4;
      if (bus.qntCount !== 16'(m_rem)) begin errors++; $display("FAIL rand_qnt c=%0d got=%0d exp=%0d", c, bus.qntCount, m_rem); end
      if (bus.intSig !== m_pending) begin errors++; $display("FAIL rand_intSig c=%0d got=%0b exp=%0b", c, bus.intSig, m_pending); end
      if (bus.armed !== m_running) begin errors++; $display("FAIL rand_armed c=%0d got=%0b exp=%0b", c, bus.armed, m_running); end
      if (bus.intCount !== 8'(m_acks)) begin errors++; $display("FAIL rand_intCount c=%0d got=%0d exp=%0d", c, bus.intCount, m_acks % 256); end
    end
  endtask

  // ---------------- sequence / report ----------------
  initial begin
    errors         = 0;
    checks         = 0;
    reset          = 1'b1;
    bus.WriteI     = 1'b0;
    bus.writeData  = 32'd0;
    bus.instrValid = 1'b0;
    bus.Halt       = 1'b0;
    bus.stopQnt    = 1'b0;
    model_clear();
    test_reset();
    test_basic();
    test_zero_default();
    test_halt();
    test_race();
    test_wrap_stray();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
